img_mem_responder: RTL
======================

// Module: img_mem_responder
// PURPOSE
//  On-chip image store that answers address requests from the cascade's pixel fetch path.
//  Phase 1 (LOAD): accepts one full frame as a raster-order write stream.
//  Phase 2 (SERVE): answers each addr handshake with one pixel on a valid/ready data stream.
//  Sits between the frame source and the fetcher's addr/din ports (responder side).
// PARAMETERS
//  W_DATA      8   pixel width in bits
//  IMG_WIDTH   41  image width in pixels
//  IMG_HEIGHT  50  image height in pixels
//  (local) DEPTH = IMG_WIDTH*IMG_HEIGHT; W_ADDR = $clog2(DEPTH)
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous reset, active-high
//  wr_valid       in   1       frame write beat valid
//  wr_ready       out  1       frame write beat accepted
//  wr_data        in   W_DATA  pixel, raster order
//  load_done      out  1       high while in SERVE (full frame stored)
//  frame_restart  in   1       single-cycle pulse: return to LOAD for next frame
//  addr_valid     in   1       read request valid
//  addr_ready     out  1       read request accepted
//  addr           in   W_ADDR  pixel address, y*IMG_WIDTH+x
//  dout_valid     out  1       read data valid
//  dout_ready     in   1       read data consumed
//  dout_data      out  W_DATA  read pixel
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=LOAD, wr_cnt=0, in-flight=0, output FIFO empty, restart_pend=0.
//   - Outputs: wr_ready=1, load_done=0, addr_ready=0, dout_valid=0, dout_data=0.
//   - Memory contents not reset.
//  Memory: DEPTH words, one write port, synchronous read with 1-cycle latency.
//  LOAD:
//   - wr_ready=1, addr_ready=0.
//   - Each wr_valid&wr_ready writes mem[wr_cnt], then wr_cnt++.
//   - Beat with wr_cnt==DEPTH-1 -> SERVE next cycle, wr_cnt=0, load_done=1.
//   - frame_restart in LOAD: wr_cnt=0, partial frame is discarded.
//  SERVE:
//   - wr_ready=0.
//   - addr_ready = !restart_pend && (inflight + fifo_count < 2).
//   - addr handshake at cycle N issues RAM read; data enters 2-entry output FIFO at N+1.
//   - dout_valid=1 from N+1 if FIFO was empty (latency 1).
//   - Credit rule: FIFO never overflows. Push and pop in the same cycle are both legal.
//   - Sustained 1 pixel/cycle when dout_ready is held high.
//   - dout_data and dout_valid stay stable while dout_valid&!dout_ready (no drop, no reorder).
//   - addr >= DEPTH: no RAM access; returns 0 in order, same latency.
//  frame_restart in SERVE:
//   - Sets restart_pend, which blocks new addresses the next cycle.
//   - Once inflight=0 and FIFO empty (all data drained) -> LOAD.
//   - On entry to LOAD: load_done=0, restart_pend=0.
//  Simultaneous events:
//   - frame_restart in the same cycle as an addr handshake: the request is served.
//   - frame_restart on the last LOAD beat: the restart wins; stay in LOAD with wr_cnt=0.
//  Reset mid-operation: in-flight reads and FIFO contents are dropped; return to LOAD.
//  No combinational path from addr_valid to addr_ready.
// TESTING
//  1. Load ramp mem[i]=i%256 (2050 beats); read addr 0,40,41,2049 -> 0,40,41,1; load_done rises after beat 2050.
//  2. Back-to-back reads 100..199 with dout_ready=1 -> 100 beats in 100 consecutive cycles, first data 1 cycle after addr 100.
//  3. dout_ready random 30% -> all data in order, unchanged while stalled; FIFO never more than 2 entries.
//  4. addr=2050 and addr=4095 -> dout_data=0, order preserved around neighbouring valid reads.
//  5. frame_restart with 2 reads pending -> both delivered, then wr_ready=1, load_done=0; reload inverted ramp, addr 5 -> 250.
//  6. Assert rst for 1 cycle during SERVE with 2 FIFO entries -> dout_valid=0 immediately; wr_ready=1; wr_cnt=0.

Source files
------------

// File: rtl/img_mem_responder_if.sv
// Bus between the frame source / pixel fetcher and the image store.
// The responder drives the ready/valid-back side through the slave modport.
interface img_mem_responder_if #(
    parameter int unsigned W_DATA = 8,
    parameter int unsigned W_ADDR = 12
);

    // Frame load stream
    logic              wr_valid;
    logic              wr_ready;
    logic [W_DATA-1:0] wr_data;
    logic              load_done;
    logic              frame_restart;

    // Read request / read data streams
    logic              addr_valid;
    logic              addr_ready;
    logic [W_ADDR-1:0] addr;
    logic              dout_valid;
    logic              dout_ready;
    logic [W_DATA-1:0] dout_data;

    modport master (
        output wr_valid,
        output wr_data,
        output frame_restart,
        output addr_valid,
        output addr,
        output dout_ready,
        input  wr_ready,
        input  load_done,
        input  addr_ready,
        input  dout_valid,
        input  dout_data
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  frame_restart,
        input  addr_valid,
        input  addr,
        input  dout_ready,
        output wr_ready,
        output load_done,
        output addr_ready,
        output dout_valid,
        output dout_data
    );

endinterface

// File: rtl/img_mem_responder.sv
// On-chip image store: loads one raster-order frame, then answers pixel address
// requests with one pixel each on a valid/ready stream (1-cycle latency, 2 credits).
module img_mem_responder #(
    parameter int unsigned W_DATA     = 8,
    parameter int unsigned IMG_WIDTH  = 41,
    parameter int unsigned IMG_HEIGHT = 50
) (
    input logic                clk,
    input logic                rst,
    img_mem_responder_if.slave bus
);

    localparam int unsigned DEPTH  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned W_ADDR = $clog2(DEPTH);

    localparam logic [W_ADDR-1:0] LAST_IDX = W_ADDR'(DEPTH - 1);
    localparam logic [W_ADDR:0]   DEPTH_W  = (W_ADDR + 1)'(DEPTH);

    typedef enum logic [0:0] {
        StLoad,
        StServe
    } state_e;

    state_e            state_q, state_d;
    logic [W_ADDR-1:0] wr_cnt_q, wr_cnt_d;
    logic              restart_pend_q, restart_pend_d;

    // Read pipeline: inflight_q means ram_q holds the answer to last cycle's request.
    logic              inflight_q, inflight_d;
    logic              rd_oob_q, rd_oob_d;
    logic [W_DATA-1:0] ram_q;
    logic [W_DATA-1:0] mem [DEPTH];

    logic [W_DATA-1:0] fifo_q [2];
    logic              fifo_rd_q, fifo_rd_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;

    logic              wr_fire;
    logic              addr_fire;
    logic              addr_in_range;
    logic              mem_re;
    logic              fifo_empty;
    logic [1:0]        occupancy;
    logic [W_DATA-1:0] rd_data;
    logic              dout_fire;
    logic              fifo_push;
    logic              fifo_pop;
    logic              drained;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign fifo_empty    = (fifo_cnt_q == 2'd0);
    assign occupancy     = {1'b0, inflight_q} + fifo_cnt_q;
    assign drained       = !inflight_q && fifo_empty;

    // addr_ready depends on registered state only, never on addr_valid.
    assign bus.wr_ready   = (state_q == StLoad);
    assign bus.load_done  = (state_q == StServe);
    assign bus.addr_ready = (state_q == StServe) && !restart_pend_q && (occupancy < 2'd2);

    assign wr_fire       = bus.wr_valid && bus.wr_ready;
    assign addr_fire     = bus.addr_valid && bus.addr_ready;
    assign addr_in_range = ({1'b0, bus.addr} < DEPTH_W);
    assign mem_re        = addr_fire && addr_in_range;

    // ------------------------------------------------------------------
    // Load / serve FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        restart_pend_d = restart_pend_q;

        unique case (state_q)
            StLoad: begin
                // A restart discards the partial frame, even on the final beat.
                if (bus.frame_restart) begin
                    wr_cnt_d = '0;
                end else if (wr_fire) begin
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = StServe;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            StServe: begin
                if (bus.frame_restart) begin
                    restart_pend_d = 1'b1;
                end
                if (restart_pend_q && drained) begin
                    restart_pend_d = 1'b0;
                    wr_cnt_d       = '0;
                    state_d        = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StLoad;
            wr_cnt_q       <= '0;
            restart_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            restart_pend_q <= restart_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame memory: single write port, registered read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_cnt_q] <= bus.wr_data;
        end
        if (mem_re) begin
            ram_q <= mem[bus.addr];
        end
    end

    assign inflight_d = addr_fire;
    assign rd_oob_d   = addr_fire && !addr_in_range;
    assign rd_data    = rd_oob_q ? '0 : ram_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: RAM data bypasses to dout when the FIFO is empty,
    // otherwise it queues behind the older entries.
    // ------------------------------------------------------------------
    assign bus.dout_valid = inflight_q || !fifo_empty;
    assign dout_fire      = bus.dout_valid && bus.dout_ready;
    assign fifo_pop       = dout_fire && !fifo_empty;
    assign fifo_push      = inflight_q && !(dout_fire && fifo_empty);

    always_comb begin
        bus.dout_data = '0;
        if (!fifo_empty) begin
            bus.dout_data = fifo_q[fifo_rd_q];
        end else if (inflight_q) begin
            bus.dout_data = rd_data;
        end
    end

    always_comb begin
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
        if (fifo_pop) begin
            fifo_rd_d = ~fifo_rd_q;
        end
        if (fifo_push) begin
            fifo_wr_d = ~fifo_wr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_q[fifo_wr_q] <= rd_data;
            end
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule
